ufm_initload_ctrl: RTL and testbench

- Boot-time copy sequencer: after reset, streams WORD_COUNT 32-bit words from the UFM read port (Avalon-MM pipelined read master) into on-chip RAM (Avalon-MM write master).
- Raises coe_initdone when the copy is complete; coe_initdone drives the board status LED and gates the CPU reset.
- Sits inside the test-memory core between the UFM data interface and the RAM s2 port.

---
 rtl/ufm_initload_pkg.sv | 28 ++
 rtl/ufm_initload_fifo.sv | 81 ++++++++
 rtl/ufm_initload_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ufm_initload_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ufm_initload_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ufm_initload_pkg
// Description : Shared types, constants and width helpers for the UFM
//               boot-time copy sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ufm_initload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    function automatic int credit_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    // A zero-length copy still needs a 1-bit counter to hold the value 0.
    function automatic int count_width(input int word_count);
        return (word_count < 1) ? 1 : $clog2(word_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ufm_initload_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ufm_initload_fifo
// Description : Synchronous show-ahead FIFO buffering UFM read data ahead of
//               the RAM write master. DEPTH must be a power of 2.
// Revision    : 1.0 - initial release
// ============================================================================
module ufm_initload_fifo
    import ufm_initload_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = credit_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_depth);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // A push into a full FIFO is legal only when the head leaves that cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_push && o_full && !i_pop))
                else $error("ufm_initload_fifo: push while full");
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ufm_initload_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ufm_initload_ctrl
// Description : Boot-time sequencer copying WORD_COUNT words from the UFM
//               read port into on-chip RAM, then raising coe_initdone.
// Revision    : 1.0 - initial release
// ============================================================================
module ufm_initload_ctrl
    import ufm_initload_pkg::*;
#(
    parameter logic [31:0] SRC_BASE    = 32'h0000_0000,
    parameter logic [31:0] DST_BASE    = 32'h0000_0000,
    parameter int          WORD_COUNT  = 1024,
    parameter int          MAX_PENDING = 4
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        coe_reload,
    output logic        coe_initdone,
    output logic [31:0] avm_rd_address,
    output logic        avm_rd_read,
    input  logic        avm_rd_waitrequest,
    input  logic [31:0] avm_rd_readdata,
    input  logic        avm_rd_readdatavalid,
    output logic [31:0] avm_wr_address,
    output logic        avm_wr_write,
    output logic [31:0] avm_wr_writedata,
    output logic [3:0]  avm_wr_byteenable,
    input  logic        avm_wr_waitrequest
);

    localparam int                 c_cnt_w       = count_width(WORD_COUNT);
    localparam int                 c_crd_w       = credit_width(MAX_PENDING);
    localparam logic [c_cnt_w-1:0] c_word_count  = c_cnt_w'(WORD_COUNT);
    localparam logic [c_cnt_w-1:0] c_last_word   = c_cnt_w'((WORD_COUNT > 0) ? WORD_COUNT - 1 : 0);
    localparam logic [c_crd_w-1:0] c_max_pending = c_crd_w'(MAX_PENDING);
    localparam logic [31:0]        c_addr_step   = 32'(WORD_BYTES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clear;
    logic               w_rd_req;
    logic               w_wr_req;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic [c_cnt_w-1:0] r_issued;
    logic [c_cnt_w-1:0] r_written;
    logic [c_crd_w-1:0] r_outstanding;
    logic [c_crd_w-1:0] w_in_flight;
    logic [31:0]        r_rd_addr;
    logic [31:0]        r_wr_addr;
    logic [31:0]        w_fifo_head;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [c_crd_w-1:0] w_fifo_count;

    // Every issued-but-unwritten word holds a credit until its write is accepted.
    assign w_in_flight = r_outstanding + w_fifo_count;
    assign w_rd_acc    = w_rd_req && !avm_rd_waitrequest;
    assign w_wr_acc    = w_wr_req && !avm_wr_waitrequest;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_rd_req    = 1'b0;
        w_wr_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_rd_req = (r_issued < c_word_count) && (w_in_flight < c_max_pending);
                w_wr_req = !w_fifo_empty;
                // Leave RUN on the same edge that accepts the final write.
                if ((r_written == c_word_count) ||
                    (w_wr_acc && (r_written == c_last_word))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (coe_reload) begin
                    w_state_nxt = ST_RUN;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            r_issued      <= '0;
            r_written     <= '0;
            r_outstanding <= '0;
            r_rd_addr     <= SRC_BASE;
            r_wr_addr     <= DST_BASE;
        end else if (w_clear) begin
            r_issued      <= '0;
            r_written     <= '0;
            r_outstanding <= '0;
            r_rd_addr     <= SRC_BASE;
            r_wr_addr     <= DST_BASE;
        end else begin
            if (w_rd_acc) begin
                r_rd_addr <= r_rd_addr + c_addr_step;
                r_issued  <= r_issued + 1'b1;
            end
            if (w_wr_acc) begin
                r_wr_addr <= r_wr_addr + c_addr_step;
                r_written <= r_written + 1'b1;
            end
            case ({w_rd_acc, avm_rd_readdatavalid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    ufm_initload_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (32),
        .CNT_W (c_crd_w)
    ) u_fifo (
        .clk         (csi_clk),
        .rst_n       (rsi_reset_n),
        .i_push      (avm_rd_readdatavalid),
        .i_push_data (avm_rd_readdata),
        .i_pop       (w_wr_acc),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_count     (w_fifo_count)
    );

    assign coe_initdone      = (r_state == ST_DONE);
    assign avm_rd_address    = r_rd_addr;
    assign avm_rd_read       = w_rd_req;
    assign avm_wr_address    = r_wr_addr;
    assign avm_wr_write      = w_wr_req;
    assign avm_wr_writedata  = w_wr_req ? w_fifo_head : 32'h0;
    assign avm_wr_byteenable = 4'b1111;

`ifndef SYNTHESIS
    always_ff @(posedge csi_clk) begin
        if (rsi_reset_n) begin
            assert (!(w_fifo_full && (r_outstanding != '0)))
                else $error("ufm_initload_ctrl: words in flight exceed credits");
            assert (!(avm_rd_readdatavalid && (r_outstanding == '0)))
                else $error("ufm_initload_ctrl: read data with no read outstanding");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ufm_initload_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ufm_initload_ctrl
// Description : Self-checking bench for ufm_initload_ctrl with UFM/RAM slave
//               models and a write-expectation scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ufm_initload_ctrl;

    localparam logic [31:0] SRC_BASE    = 32'h0001_0000;
    localparam logic [31:0] DST_BASE    = 32'h0000_4000;
    localparam int          WORD_COUNT  = 256;
    localparam int          MAX_PENDING = 4;
    localparam int          BUDGET      = 5000;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        reload  = 1'b0;
    logic        rd_wait = 1'b0;
    logic        rdv     = 1'b0;
    logic [31:0] rdata   = 32'h0;
    logic        wr_wait = 1'b0;

    logic        initdone, rd_read, wr_write;
    logic [31:0] rd_addr, wr_addr, wdata;
    logic [3:0]  be;
    logic        z_initdone, z_rd_read, z_wr_write;
    logic [31:0] z_rd_addr, z_wr_addr, z_wdata;
    logic [3:0]  z_be;

    always #5 clk = ~clk;

    ufm_initload_ctrl #(
        .SRC_BASE (SRC_BASE), .DST_BASE (DST_BASE),
        .WORD_COUNT (WORD_COUNT), .MAX_PENDING (MAX_PENDING)
    ) dut (
        .csi_clk (clk), .rsi_reset_n (rst_n), .coe_reload (reload),
        .coe_initdone (initdone),
        .avm_rd_address (rd_addr), .avm_rd_read (rd_read),
        .avm_rd_waitrequest (rd_wait), .avm_rd_readdata (rdata),
        .avm_rd_readdatavalid (rdv),
        .avm_wr_address (wr_addr), .avm_wr_write (wr_write),
        .avm_wr_writedata (wdata), .avm_wr_byteenable (be),
        .avm_wr_waitrequest (wr_wait)
    );

    ufm_initload_ctrl #(
        .SRC_BASE (SRC_BASE), .DST_BASE (DST_BASE),
        .WORD_COUNT (0), .MAX_PENDING (MAX_PENDING)
    ) dut_zero (
        .csi_clk (clk), .rsi_reset_n (rst_n), .coe_reload (1'b0),
        .coe_initdone (z_initdone),
        .avm_rd_address (z_rd_addr), .avm_rd_read (z_rd_read),
        .avm_rd_waitrequest (1'b0), .avm_rd_readdata (32'h0),
        .avm_rd_readdatavalid (1'b0),
        .avm_wr_address (z_wr_addr), .avm_wr_write (z_wr_write),
        .avm_wr_writedata (z_wdata), .avm_wr_byteenable (z_be),
        .avm_wr_waitrequest (1'b0)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [63:0] sb_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mode = 0;
    int          cyc, rd_cnt, wr_cnt, last_wr_cyc, stall_left;
    bit          stall_used, z_seen, hit;
    logic [31:0] salt = 32'h0;
    logic        prev_rd_stall, prev_wr_stall;
    logic [31:0] prev_rd_addr, prev_wr_addr, prev_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ufm_word(input int idx);
        return (32'hA5A5_0000 + 32'(idx)) ^ salt;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_initdone"}, initdone, 0);
        check_eq({tag, "_rd_read"},  rd_read,  0);
        check_eq({tag, "_wr_write"}, wr_write, 0);
        check_eq({tag, "_rd_addr"},  rd_addr,  SRC_BASE);
        check_eq({tag, "_wr_addr"},  wr_addr,  DST_BASE);
        check_eq({tag, "_wdata"},    wdata,    0);
        check_eq({tag, "_be"},       be,       4'hF);
        check_eq({tag, "_z_initdone"}, z_initdone, 0);
        check_eq({tag, "_z_addrs"}, z_rd_addr ^ z_wr_addr ^ z_wdata, SRC_BASE ^ DST_BASE);
        check_eq({tag, "_z_be"},     z_be,     4'hF);
    endtask

    task automatic clear_bench();
        cyc = 0; rd_cnt = 0; wr_cnt = 0; last_wr_cyc = -10;
        stall_left = 0; stall_used = 1'b0;
        prev_rd_stall = 1'b0; prev_wr_stall = 1'b0;
        rsp_q.delete();
        sb_q.delete();
    endtask

    // One bus cycle: drive slave inputs at the falling edge, then judge the
    // handshakes that the next rising edge will complete.
    task automatic step();
        int          lat;
        logic [31:0] w;
        logic [63:0] exp;
        @(negedge clk);
        cyc++;
        reload = 1'b0;
        if (mode == 1 && wr_cnt == 10 && !stall_used) begin
            stall_left = 20;
            stall_used = 1'b1;
        end
        if (stall_left > 0) begin
            wr_wait = 1'b1;
            stall_left--;
        end else begin
            wr_wait = (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        rd_wait = (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            rdv   = 1'b1;
            rdata = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            rdv   = 1'b0;
            rdata = 32'h0BAD_F00D;
        end
        #1;
        z_seen = z_seen | z_rd_read | z_wr_write;
        if (prev_rd_stall) begin
            check_eq("rd_hold_read", rd_read, 1);
            check_eq("rd_hold_addr", rd_addr, prev_rd_addr);
        end
        if (prev_wr_stall) begin
            check_eq("wr_hold_write", wr_write, 1);
            check_eq("wr_hold_addr", wr_addr, prev_wr_addr);
            check_eq("wr_hold_data", wdata, prev_wdata);
        end
        if (rd_read && !rd_wait) begin
            check_eq("rd_within_count", rd_cnt < WORD_COUNT, 1);
            check_eq("rd_credit", (rd_cnt - wr_cnt) < MAX_PENDING, 1);
            check_eq("rd_addr", rd_addr, SRC_BASE + 32'(rd_cnt * 4));
            lat = (mode == 2) ? int'($urandom_range(1, 3)) : 2;
            w   = ufm_word(rd_cnt);
            rsp_q.push_back('{cyc + lat, w});
            sb_q.push_back({DST_BASE + 32'(rd_cnt * 4), w});
            rd_cnt++;
        end
        if (wr_write && !wr_wait) begin
            check_eq("wr_expected", sb_q.size() > 0, 1);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'h0;
            check_eq("wr_addr", wr_addr, exp[63:32]);
            check_eq("wr_data", wdata, exp[31:0]);
            check_eq("wr_initdone_low", initdone, 0);
            wr_cnt++;
            if (wr_cnt == WORD_COUNT) last_wr_cyc = cyc;
        end
        prev_rd_stall = rd_read && rd_wait;
        prev_rd_addr  = rd_addr;
        prev_wr_stall = wr_write && wr_wait;
        prev_wr_addr  = wr_addr;
        prev_wdata    = wdata;
    endtask

    task automatic run_copy(input int m, input int reload_at_wr, input int reset_at_wr,
                            output bit reset_hit);
        bit done = 1'b0;
        bit reload_sent = 1'b0;
        mode = m;
        reset_hit = 1'b0;
        for (int i = 0; i < BUDGET && !done && !reset_hit; i++) begin
            step();
            if (reset_at_wr > 0 && wr_cnt == reset_at_wr) begin
                reset_hit = 1'b1;
            end else begin
                if (reload_at_wr >= 0 && wr_cnt == reload_at_wr && !reload_sent) begin
                    reload      = 1'b1;
                    reload_sent = 1'b1;
                end
                if (wr_cnt == WORD_COUNT && cyc == last_wr_cyc + 1) begin
                    check_eq("initdone_rise", initdone, 1);
                    check_eq("done_rd_idle", rd_read, 0);
                    check_eq("done_wr_idle", wr_write, 0);
                    check_eq("rd_total", rd_cnt, WORD_COUNT);
                    check_eq("sb_drained", sb_q.size(), 0);
                    if (m == 0) check_eq("throughput", last_wr_cyc <= WORD_COUNT + 8, 1);
                    done = 1'b1;
                end
            end
        end
        if (!done && !reset_hit) check_eq("copy_complete", {wr_cnt == WORD_COUNT, done}, 2'b11);
    endtask

    task automatic release_and_check_zero();
        rst_n = 1'b1;
        clear_bench();
        step();
        check_eq("zero_edge1_initdone", z_initdone, 0);
        check_eq("main_edge1_initdone", initdone, 0);
        step();
        check_eq("zero_edge2_initdone", z_initdone, 1);
    endtask

    initial begin
        z_seen = 1'b0;
        clear_bench();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        release_and_check_zero();
        run_copy(0, -1, 0, hit);

        salt = 32'h0F0F_1234;
        clear_bench();
        reload = 1'b1;
        step();
        check_eq("reload_fall_1", initdone, 0);
        run_copy(1, 5, 0, hit);

        salt = 32'h3C3C_5A5A;
        clear_bench();
        reload = 1'b1;
        step();
        check_eq("reload_fall_2", initdone, 0);
        run_copy(2, -1, 0, hit);

        salt = 32'h1234_8765;
        clear_bench();
        reload = 1'b1;
        step();
        run_copy(2, -1, 100, hit);
        check_eq("reset_point_reached", hit, 1);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        rdv = 1'b0; rd_wait = 1'b0; wr_wait = 1'b0;
        rsp_q.delete();
        sb_q.delete();
        repeat (2) @(negedge clk);
        release_and_check_zero();
        run_copy(2, -1, 0, hit);

        check_eq("zero_no_bus", z_seen, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
